// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter block.
//   - Operation encodings seen on req0_op / req1_op.
//   - FSM state encoding used by shift_arbiter.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ROT2 = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational left-only barrel shifter with zero fill.
// One stage per amount bit; stage s shifts by 2**s when amt[s] is set.
// Ports:
//   x    in   WIDTH  operand
//   amt  in   AMT_W  left-shift amount
//   y    out  WIDTH  x << amt, zero filled
module barrel_shift_core #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] stage [0:AMT_W];

    assign stage[0] = x;

    for (genvar s = 0; s < AMT_W; s++) begin : g_stage
        assign stage[s+1] = amt[s] ? (stage[s] << (1 << s)) : stage[s];
    end

    assign y = stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing a single left barrel shifter.
// Right shifts run the core on bit-reversed data and reverse the result;
// ROR takes a second pass (data << (-amt mod WIDTH)) ORed into the first.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid / req_ready per-requester handshake (ready only in IDLE, one-hot)
//   req0_data/amt/op      requester 0 operation fields
//   req1_data/amt/op      requester 1 operation fields
//   out_valid / out_ready result handshake
//   out_data / out_id     registered result and issuing requester
//   busy                  high whenever the FSM is not idle
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [1:0]       req1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             accept;

    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    logic [1:0]       op_q;
    logic             id_q;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] core_x;
    logic [AMT_W-1:0] core_amt;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] core_rev;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] exec_res;

    // Bit reversal of the operand and of the core output, plus the SRA sign
    // fill mask: bit i is set when i >= WIDTH-amt, i.e. the top amt bits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        localparam logic [AMT_W:0] THR = (AMT_W+1)'(WIDTH - 1 - i);
        assign data_rev[i]  = data_q[WIDTH-1-i];
        assign core_rev[i]  = core_y[WIDTH-1-i];
        assign fill_mask[i] = ({1'b0, amt_q} > THR);
    end

    barrel_shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .x   (core_x),
        .amt (core_amt),
        .y   (core_y)
    );

    // Core input select: the second ROR pass shifts the raw operand left by
    // the two's-complement amount, which wraps mod WIDTH in AMT_W bits.
    always_comb begin
        core_x   = (op_q == OP_SLL) ? data_q : data_rev;
        core_amt = amt_q;
        if (state == ST_ROT2) begin
            core_x   = data_q;
            core_amt = AMT_W'(0) - amt_q;
        end
    end

    always_comb begin
        exec_res = (op_q == OP_SLL) ? core_y : core_rev;
        if ((op_q == OP_SRA) && data_q[WIDTH-1]) begin
            exec_res = exec_res | fill_mask;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ((op_q == OP_ROR) && (amt_q != '0)) ? ST_ROT2 : ST_DONE;
            ST_ROT2: state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. Grants only in IDLE; a contested cycle goes to rr_ptr.
    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE) begin
            if (req_valid == 2'b11) begin
                req_ready = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                req_ready = req_valid;
            end
        end
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    // req_ready is a subset of req_valid, so any ready bit is a transfer.
    assign accept   = |req_ready;
    assign out_data = acc;
    assign out_id   = id_q;

    // Operand capture and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            id_q   <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q <= req_ready[1] ? req1_data : req0_data;
                        amt_q  <= req_ready[1] ? req1_amt  : req0_amt;
                        op_q   <= req_ready[1] ? req1_op   : req0_op;
                        id_q   <= req_ready[1];
                        rr_ptr <= ~req_ready[1];
                    end
                end
                ST_EXEC: acc <= exec_res;
                ST_ROT2: acc <= acc | core_y;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_data = '0;
    logic [AMT_W-1:0] req0_amt = '0;
    logic [1:0]       req0_op = 2'b00;
    logic [WIDTH-1:0] req1_data = '0;
    logic [AMT_W-1:0] req1_amt = '0;
    logic [1:0]       req1_op = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_data (req0_data),
        .req0_amt  (req0_amt),
        .req0_op   (req0_op),
        .req1_data (req1_data),
        .req1_amt  (req1_amt),
        .req1_op   (req1_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) on negedges until out_valid; n counts negedges waited.
    task automatic wait_out(input string tag, inout int n);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Issues one op from an idle negedge and consumes the result with
    // out_ready high; returns at the negedge after the output transfer.
    task automatic run_op(input string tag, input bit id, input logic [31:0] data,
                          input logic [4:0] amt, input logic [1:0] op,
                          input logic [31:0] exp, input int lat);
        int n;
        if (id) begin
            req1_data = data; req1_amt = amt; req1_op = op;
        end else begin
            req0_data = data; req0_amt = amt; req0_op = op;
        end
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        check({tag, "_ready"}, 32'(req_ready), id ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        n = 1;
        wait_out(tag, n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_data"}, out_data, exp);
        check({tag, "_id"}, 32'(out_id), 32'(id));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd0);

        // Contested request right after reset prefers req0; drop it ungranted
        req_valid = 2'b11;
        #1;
        check("rst_rr_ptr", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        @(negedge clk);
        check("drop_no_effect", 32'(busy), 32'd0);

        // 1: SLL by 31
        run_op("t1_sll31", 1'b0, 32'h0000_0001, 5'd31, SLL, 32'h8000_0000, 2);

        // 2: SRA / SRL / boundaries
        run_op("t2_sra4", 1'b1, 32'h8000_0000, 5'd4, SRA, 32'hF800_0000, 2);
        run_op("t2_srl4", 1'b1, 32'h8000_0000, 5'd4, SRL, 32'h0800_0000, 2);
        run_op("t2_sra31", 1'b1, 32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF, 2);
        run_op("t2_sra_pos", 1'b1, 32'h7000_0000, 5'd8, SRA, 32'h0070_0000, 2);
        run_op("t2_sra0", 1'b1, 32'h8765_4321, 5'd0, SRA, 32'h8765_4321, 2);

        // 3: ROR two-pass and single-pass
        run_op("t3_ror4", 1'b0, 32'h0000_00F1, 5'd4, ROR, 32'h1000_000F, 3);
        run_op("t3_ror0", 1'b1, 32'hDEAD_BEEF, 5'd0, ROR, 32'hDEAD_BEEF, 2);

        // 4: both requesters held valid -> alternating grants 0,1,0,1
        req0_data = 32'h0000_0003; req0_amt = 5'd1; req0_op = SLL;
        req1_data = 32'h8000_0000; req1_amt = 5'd1; req1_op = SRL;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_grant", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk);
            @(negedge clk);
            n = 1;
            wait_out("t4", n);
            check("t4_busy_ready", 32'(req_ready), 32'd0);
            check("t4_out_id", 32'(out_id), 32'(k % 2));
            check("t4_out_data", out_data, (k % 2 == 1) ? 32'h4000_0000 : 32'h0000_0006);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // 5: back-pressure in DONE
        out_ready = 1'b0;
        req0_data = 32'h1234_5678; req0_amt = 5'd4; req0_op = SLL;
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        n = 1;
        wait_out("t5", n);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_data", out_data, 32'h2345_6780);
            check("t5_hold_id", 32'(out_id), 32'd0);
            check("t5_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("t5_transfer_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t5_after_valid", 32'(out_valid), 32'd0);
        check("t5_next_grant", 32'(req_ready), 32'd2);
        req_valid = 2'b00;
        @(negedge clk);

        // 6: reset during ROT2 (req0 op leaves rr_ptr=1 before reset)
        req0_data = 32'h0000_00F1; req0_amt = 5'd4; req0_op = ROR;
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("t6_exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t6_rot2_busy", 32'(busy), 32'd1);
        check("t6_rot2_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        req_valid = 2'b11;
        #1;
        check("t6_rst_rr_ptr", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        @(negedge clk);
        check("t6_no_stale_valid", 32'(out_valid), 32'd0);
        run_op("t6_sll0", 1'b0, 32'hCAFE_BABE, 5'd0, SLL, 32'hCAFE_BABE, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
